// File: rtl/rtt_probe_pkg.sv
// Shared definitions for the RTT probe receive path: parser states, frame
// layout constants and the saturating byte-counter helper.
package rtt_probe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_STAMP,
        ST_WAIT_END,
        ST_SKIP
    } rx_state_e;

    localparam int ETH_TYPE_OFFSET = 12;
    localparam int STAMP_BYTES     = 8;
    localparam int TS_WIDTH        = 64;
    localparam int CNT_W           = 11;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/rtt_result_fifo.sv
// First-word-fall-through synchronous FIFO holding computed RTT results.
// Head reads as zero while empty so the readout register never shows stale data.
module rtt_result_fifo #(
    parameter int DATA_W    = 64,
    parameter int ADDR_BITS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [ADDR_BITS:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS:0] rd_ptr_q, rd_ptr_d;
    logic               do_rd, do_wr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[ADDR_BITS] != rd_ptr_q[ADDR_BITS]) &&
                     (wr_ptr_q[ADDR_BITS-1:0] == rd_ptr_q[ADDR_BITS-1:0]);

    assign do_rd = rd_en_i && !empty_o;
    assign do_wr = wr_en_i && (!full_o || do_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[ADDR_BITS-1:0]] <= wr_data_i;
    end

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[ADDR_BITS-1:0]];

endmodule

// File: rtl/rtt_rx_stamper.sv
// Snoops the GMAC RX byte stream, stamps probe frames at start of frame and
// queues RTT = sof_stamp - echoed tx_stamp for register readout.
module rtt_rx_stamper
    import rtt_probe_pkg::*;
#(
    parameter logic [15:0] PROBE_ETHERTYPE = 16'h88B5,
    parameter int          STAMP_OFFSET    = 14,
    parameter int          FIFO_ADDR_BITS  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [TS_WIDTH-1:0] count64,
    input  logic [7:0]          gmac_rx_data,
    input  logic                gmac_rx_dvld,
    input  logic                gmac_rx_goodframe,
    input  logic                gmac_rx_badframe,
    input  logic                rtt_rd,
    output logic [TS_WIDTH-1:0] rtt_data,
    output logic                rtt_valid,
    output logic                probe_good,
    output logic                probe_bad,
    output logic                rtt_overflow
);

    localparam logic [CNT_W-1:0] ETH_HI      = CNT_W'(ETH_TYPE_OFFSET);
    localparam logic [CNT_W-1:0] ETH_LO      = CNT_W'(ETH_TYPE_OFFSET + 1);
    localparam logic [CNT_W-1:0] STAMP_FIRST = CNT_W'(STAMP_OFFSET);
    localparam logic [CNT_W-1:0] STAMP_LAST  = CNT_W'(STAMP_OFFSET + STAMP_BYTES - 1);

    rx_state_e           state_q, state_d;
    logic                dvld_prev_q;
    logic [CNT_W-1:0]    byte_cnt_q;
    logic                etype_hi_ok_q;
    logic [TS_WIDTH-1:0] sof_stamp_q, tx_stamp_q;
    logic                probe_good_q, probe_bad_q, overflow_q;
    logic                sof, eof, push_req, bad_req, accept;
    logic                fifo_full, fifo_empty;
    logic [TS_WIDTH-1:0] rtt_calc;

    // Left unreset so it keeps tracking dvld while reset is held: a frame already
    // in flight at release then never produces a rising edge and is skipped.
    always_ff @(posedge clk) dvld_prev_q <= gmac_rx_dvld;

    assign sof = gmac_rx_dvld && !dvld_prev_q;
    assign eof = gmac_rx_goodframe || gmac_rx_badframe;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (sof)               state_d = enable ? ST_HDR : ST_SKIP;
                else if (gmac_rx_dvld) state_d = ST_SKIP;
            end
            ST_HDR: begin
                if (eof) state_d = ST_IDLE;
                else if (gmac_rx_dvld) begin
                    if (byte_cnt_q == ETH_LO &&
                        (!etype_hi_ok_q || gmac_rx_data != PROBE_ETHERTYPE[7:0]))
                        state_d = ST_SKIP;
                    else if (byte_cnt_q == STAMP_FIRST)
                        state_d = ST_STAMP;
                end
            end
            ST_STAMP: begin
                if (eof)                                           state_d = ST_IDLE;
                else if (gmac_rx_dvld && byte_cnt_q == STAMP_LAST) state_d = ST_WAIT_END;
            end
            ST_WAIT_END: if (eof) state_d = ST_IDLE;
            ST_SKIP:     if (eof || !gmac_rx_dvld) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // A runt is only reported once the EtherType has been seen and matched.
    always_comb begin
        push_req = 1'b0;
        bad_req  = 1'b0;
        unique case (state_q)
            ST_HDR:      bad_req  = eof && (byte_cnt_q > ETH_LO);
            ST_STAMP:    bad_req  = eof;
            ST_WAIT_END: begin
                push_req = gmac_rx_goodframe;
                bad_req  = gmac_rx_badframe && !gmac_rx_goodframe;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt_q    <= '0;
            etype_hi_ok_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && sof)
                byte_cnt_q <= CNT_W'(1);
            else if ((state_q == ST_HDR || state_q == ST_STAMP) && gmac_rx_dvld)
                byte_cnt_q <= sat_inc(byte_cnt_q);
            if (state_q == ST_HDR && gmac_rx_dvld && byte_cnt_q == ETH_HI)
                etype_hi_ok_q <= (gmac_rx_data == PROBE_ETHERTYPE[15:8]);
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && sof && enable)
            sof_stamp_q <= count64;
        if (gmac_rx_dvld && ((state_q == ST_HDR && byte_cnt_q == STAMP_FIRST) ||
                             state_q == ST_STAMP))
            tx_stamp_q <= {tx_stamp_q[TS_WIDTH-9:0], gmac_rx_data};
    end

    assign rtt_calc = sof_stamp_q - tx_stamp_q;
    assign accept   = push_req && (!fifo_full || rtt_rd);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            probe_good_q <= 1'b0;
            probe_bad_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            probe_good_q <= accept;
            probe_bad_q  <= bad_req;
            overflow_q   <= push_req && !accept;
        end
    end

    rtt_result_fifo #(
        .DATA_W    (TS_WIDTH),
        .ADDR_BITS (FIFO_ADDR_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .wr_en_i   (accept),
        .wr_data_i (rtt_calc),
        .rd_en_i   (rtt_rd),
        .rd_data_o (rtt_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign rtt_valid    = !fifo_empty;
    assign probe_good   = probe_good_q;
    assign probe_bad    = probe_bad_q;
    assign rtt_overflow = overflow_q;

endmodule

// File: tb/tb_rtt_rx_stamper.sv
// Directed bench for rtt_rx_stamper: probe stamping, filtering, runts,
// FIFO full/overflow, subtraction wrap and reset in the middle of a frame.
module tb_rtt_rx_stamper;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [63:0] count64;
    logic [7:0]  gmac_rx_data;
    logic        gmac_rx_dvld;
    logic        gmac_rx_goodframe;
    logic        gmac_rx_badframe;
    logic        rtt_rd;
    logic [63:0] rtt_data;
    logic        rtt_valid;
    logic        probe_good;
    logic        probe_bad;
    logic        rtt_overflow;

    int total = 0;
    int bad   = 0;
    int n_good = 0, n_bad = 0, n_ovf = 0;
    logic [2:0] eof_flags;

    always #5 clk = ~clk;

    rtt_rx_stamper dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .count64           (count64),
        .gmac_rx_data      (gmac_rx_data),
        .gmac_rx_dvld      (gmac_rx_dvld),
        .gmac_rx_goodframe (gmac_rx_goodframe),
        .gmac_rx_badframe  (gmac_rx_badframe),
        .rtt_rd            (rtt_rd),
        .rtt_data          (rtt_data),
        .rtt_valid         (rtt_valid),
        .probe_good        (probe_good),
        .probe_bad         (probe_bad),
        .rtt_overflow      (rtt_overflow)
    );

    always @(negedge clk) begin
        if (probe_good)   n_good++;
        if (probe_bad)    n_bad++;
        if (rtt_overflow) n_ovf++;
    end

    function automatic logic [7:0] frame_byte(input int i, input logic [15:0] et,
                                              input logic [63:0] st);
        if (i == 12) return et[15:8];
        if (i == 13) return et[7:0];
        if (i >= 14 && i <= 21) return st[8*(21-i) +: 8];
        if (i < 12) return 8'(8'hA0 + i);
        return 8'h5A;
    endfunction

    task automatic send_frame(input int len, input logic [15:0] et, input logic [63:0] st,
                              input logic [63:0] cnt, input bit good,
                              input bit rd_on_eof, input int en_off);
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            if (i == 0) count64 = cnt;
            if (i == 1) count64 = cnt + 64'h7777;
            if (i == en_off) enable = 1'b0;
            gmac_rx_dvld = 1'b1;
            gmac_rx_data = frame_byte(i, et, st);
        end
        @(posedge clk); #1;
        gmac_rx_dvld      = 1'b0;
        gmac_rx_data      = 8'h00;
        gmac_rx_goodframe = good;
        gmac_rx_badframe  = !good;
        rtt_rd            = rd_on_eof;
        @(negedge clk);
        eof_flags = {probe_good, probe_bad, rtt_overflow};
        @(posedge clk); #1;
        gmac_rx_goodframe = 1'b0;
        gmac_rx_badframe  = 1'b0;
        rtt_rd            = 1'b0;
        enable            = 1'b1;
    endtask

    task automatic pop;
        @(posedge clk); #1;
        rtt_rd = 1'b1;
        @(posedge clk); #1;
        rtt_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0; enable = 1'b1; count64 = '0; gmac_rx_data = '0;
        gmac_rx_dvld = 1'b0; gmac_rx_goodframe = 1'b0; gmac_rx_badframe = 1'b0; rtt_rd = 1'b0;
        repeat (3) @(negedge clk);
        if (rtt_valid !== 1'b0) begin $display("FAIL reset_valid got=%b want=0", rtt_valid); bad++; end
        total++;
        if (rtt_data !== 64'h0) begin $display("FAIL reset_data got=%h want=0", rtt_data); bad++; end
        total++;
        if ({probe_good, probe_bad, rtt_overflow} !== 3'b000) begin
            $display("FAIL reset_pulses got=%b want=000", {probe_good, probe_bad, rtt_overflow}); bad++;
        end
        total++;
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        if (rtt_valid !== 1'b0) begin $display("FAIL post_reset_valid got=%b want=0", rtt_valid); bad++; end
        total++;
    endtask

    task automatic test_probe_good;
        int g0;
        g0 = n_good;
        send_frame(60, 16'h88B5, 64'h1000, 64'h1234, 1'b1, 1'b0, -1);
        if (eof_flags !== 3'b000) begin $display("FAIL good_early_pulse got=%b want=000", eof_flags); bad++; end
        total++;
        @(negedge clk);
        if (probe_good !== 1'b1) begin $display("FAIL good_pulse got=%b want=1", probe_good); bad++; end
        total++;
        if (rtt_valid !== 1'b1) begin $display("FAIL good_valid got=%b want=1", rtt_valid); bad++; end
        total++;
        if (rtt_data !== 64'h234) begin $display("FAIL good_rtt got=%h want=234", rtt_data); bad++; end
        total++;
        @(negedge clk);
        if (n_good - g0 !== 1) begin $display("FAIL good_count got=%0d want=1", n_good - g0); bad++; end
        total++;
        pop();
        if (rtt_valid !== 1'b0) begin $display("FAIL good_pop_empty got=%b want=0", rtt_valid); bad++; end
        total++;
    endtask

    task automatic test_non_probe;
        int g0, b0, o0;
        g0 = n_good; b0 = n_bad; o0 = n_ovf;
        send_frame(60, 16'h0800, 64'h1000, 64'h1234, 1'b1, 1'b0, -1);
        repeat (2) @(negedge clk);
        if ({n_good - g0, n_bad - b0, n_ovf - o0} !== {32'd0, 32'd0, 32'd0}) begin
            $display("FAIL ipv4_pulses got=%0d/%0d/%0d want=0/0/0", n_good - g0, n_bad - b0, n_ovf - o0); bad++;
        end
        total++;
        if (rtt_valid !== 1'b0) begin $display("FAIL ipv4_valid got=%b want=0", rtt_valid); bad++; end
        total++;
    endtask

    task automatic test_bad_and_runt;
        int g0, b0;
        g0 = n_good; b0 = n_bad;
        send_frame(60, 16'h88B5, 64'h1000, 64'h1234, 1'b0, 1'b0, -1);
        @(negedge clk);
        if (probe_bad !== 1'b1) begin $display("FAIL badframe_pulse got=%b want=1", probe_bad); bad++; end
        total++;
        @(negedge clk);
        if (n_bad - b0 !== 1) begin $display("FAIL badframe_count got=%0d want=1", n_bad - b0); bad++; end
        total++;
        if (rtt_valid !== 1'b0) begin $display("FAIL badframe_valid got=%b want=0", rtt_valid); bad++; end
        total++;
        send_frame(18, 16'h88B5, 64'h1000, 64'h1234, 1'b1, 1'b0, -1);
        @(negedge clk);
        if (probe_bad !== 1'b1) begin $display("FAIL runt_pulse got=%b want=1", probe_bad); bad++; end
        total++;
        send_frame(10, 16'h88B5, 64'h1000, 64'h1234, 1'b1, 1'b0, -1);
        repeat (2) @(negedge clk);
        if (n_bad - b0 !== 2) begin $display("FAIL runt_count got=%0d want=2", n_bad - b0); bad++; end
        total++;
        if (n_good - g0 !== 0 || rtt_valid !== 1'b0) begin
            $display("FAIL runt_push got=%0d,%b want=0,0", n_good - g0, rtt_valid); bad++;
        end
        total++;
    endtask

    task automatic test_enable;
        int g0;
        g0 = n_good;
        enable = 1'b0;
        send_frame(60, 16'h88B5, 64'h1000, 64'h1234, 1'b1, 1'b0, 0);
        repeat (2) @(negedge clk);
        if (n_good - g0 !== 0) begin $display("FAIL disabled_push got=%0d want=0", n_good - g0); bad++; end
        total++;
        send_frame(60, 16'h88B5, 64'h0300, 64'h0500, 1'b1, 1'b0, 5);
        @(negedge clk);
        if (rtt_data !== 64'h200) begin $display("FAIL en_mid_rtt got=%h want=200", rtt_data); bad++; end
        total++;
        pop();
    endtask

    task automatic test_fifo_full;
        logic [63:0] exp_r [5];
        int g0, o0;
        exp_r[0] = 64'h0F00; exp_r[1] = 64'h1011; exp_r[2] = 64'h1122;
        exp_r[3] = 64'h1233; exp_r[4] = 64'h1344;
        for (int pass = 0; pass < 2; pass++) begin
            g0 = n_good; o0 = n_ovf;
            for (int k = 0; k < 5; k++)
                send_frame(40, 16'h88B5, 64'h0100, 64'h1000 + 64'(k) * 64'h111, 1'b1,
                           (pass == 1 && k == 4), -1);
            repeat (2) @(negedge clk);
            if (n_ovf - o0 !== (pass == 0 ? 1 : 0)) begin
                $display("FAIL ovf_count_p%0d got=%0d want=%0d", pass, n_ovf - o0, pass == 0 ? 1 : 0); bad++;
            end
            total++;
            if (n_good - g0 !== (pass == 0 ? 4 : 5)) begin
                $display("FAIL full_good_p%0d got=%0d want=%0d", pass, n_good - g0, pass == 0 ? 4 : 5); bad++;
            end
            total++;
            for (int k = 0; k < 4; k++) begin
                if (rtt_valid !== 1'b1 || rtt_data !== exp_r[k + pass]) begin
                    $display("FAIL fifo_order_p%0d_%0d got=%b/%h want=1/%h", pass, k, rtt_valid,
                             rtt_data, exp_r[k + pass]); bad++;
                end
                total++;
                pop();
            end
            if (rtt_valid !== 1'b0) begin $display("FAIL fifo_drain_p%0d got=%b want=0", pass, rtt_valid); bad++; end
            total++;
        end
    endtask

    task automatic test_wrap;
        send_frame(60, 16'h88B5, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 1'b1, 1'b0, -1);
        @(negedge clk);
        if (rtt_data !== 64'h20) begin $display("FAIL wrap_rtt got=%h want=20", rtt_data); bad++; end
        total++;
        pop();
    endtask

    task automatic test_reset_mid_frame;
        int g0, b0;
        g0 = n_good; b0 = n_bad;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (i == 0)  count64 = 64'h9999;
            if (i == 20) reset = 1'b0;
            if (i == 23) reset = 1'b1;
            gmac_rx_dvld = 1'b1;
            gmac_rx_data = frame_byte(i, 16'h88B5, 64'h1000);
        end
        @(posedge clk); #1;
        gmac_rx_dvld = 1'b0; gmac_rx_goodframe = 1'b1;
        @(posedge clk); #1;
        gmac_rx_goodframe = 1'b0;
        repeat (2) @(negedge clk);
        if (n_good - g0 !== 0 || n_bad - b0 !== 0) begin
            $display("FAIL rst_mid_pulses got=%0d/%0d want=0/0", n_good - g0, n_bad - b0); bad++;
        end
        total++;
        if (rtt_valid !== 1'b0) begin $display("FAIL rst_mid_valid got=%b want=0", rtt_valid); bad++; end
        total++;
        send_frame(60, 16'h88B5, 64'h0050, 64'h1050, 1'b1, 1'b0, -1);
        @(negedge clk);
        if (rtt_valid !== 1'b1 || rtt_data !== 64'h1000) begin
            $display("FAIL rst_next_rtt got=%b/%h want=1/1000", rtt_valid, rtt_data); bad++;
        end
        total++;
        pop();
    endtask

    initial begin
        test_reset();
        test_probe_good();
        test_non_probe();
        test_bad_and_runt();
        test_enable();
        test_fifo_full();
        test_wrap();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
